multicycle_control: RTL and testbench

//  Main control FSM for the multi-cycle RISC-V core. Sequences fetch/decode/execute/memory/writeback over the shared
//  ALU, register file and unified memory port. Drives ALUOP to the ALU control decoder; selects ALU operands,

---
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch/decode/execute/memory/writeback
// over the shared ALU, register file and unified memory port, with a memory-wait timeout trap.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [2:0] aluop,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [3:0] state,
  output logic       error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EX_R     = 4'd3,
    S_EX_I     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_EX_U     = 4'd12,
    S_ERR      = 4'd15
  } state_t;

  state_t           state_q;
  state_t           state_d;
  state_t           end_d;
  logic [CNT_W-1:0] wait_q;
  logic             timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (mem_req && !mem_ready)
        wait_q <= wait_q + CNT_W'(1);
    end
  end

  // Terminal count: one more unanswered request cycle means the memory has hung.
  assign timeout = (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign end_d   = start ? S_FETCH : S_IDLE;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    aluop      = 3'b000;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    result_src = 2'd0;
    error      = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 2'd3;
        alu_src_b = 2'd2;
        aluop     = 3'b010;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_ERR;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        aluop     = 3'b010;
        case (opcode)
          OP_R:               state_d = S_EX_R;
          OP_I:               state_d = S_EX_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BR:              state_d = S_BRANCH;
          OP_JAL, OP_JALR:    state_d = S_JUMP;
          OP_LUI, OP_AUIPC:   state_d = S_EX_U;
          default:            state_d = S_ERR;
        endcase
      end
      S_EX_R: state_d = S_WB_ALU;
      S_EX_I: begin
        alu_src_b = 2'd1;
        aluop     = 3'b001;
        state_d   = S_WB_ALU;
      end
      S_EX_U: begin
        alu_src_b = 2'd1;
        alu_src_a = (opcode == OP_LUI) ? 2'd2 : 2'd1;
        aluop     = (opcode == OP_LUI) ? 3'b101 : 3'b110;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_b = 2'd1;
        aluop     = (opcode == OP_STORE) ? 3'b011 : 3'b010;
        state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ready)    state_d = S_WB_MEM;
        else if (timeout) state_d = S_ERR;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (mem_ready)    state_d = end_d;
        else if (timeout) state_d = S_ERR;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = end_d;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 2'd1;
        state_d    = end_d;
      end
      // PC takes the target computed during DECODE only when the condition holds.
      S_BRANCH: begin
        aluop    = 3'b100;
        pc_write = branch_taken;
        state_d  = end_d;
      end
      S_JUMP: begin
        aluop      = 3'b111;
        reg_write  = 1'b1;
        result_src = 2'd2;
        pc_write   = 1'b1;
        alu_src_a  = (opcode == OP_JAL) ? 2'd1 : 2'd0;
        alu_src_b  = 2'd1;
        state_d    = end_d;
      end
      S_ERR:   error   = 1'b1;
      default: state_d = S_ERR;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected output traces built from the
// instruction class and randomized memory wait lengths, compared cycle by cycle.
module tb_multicycle_control;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n, start, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, error;
  logic [2:0] aluop;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  bit          rdy_q[$];
  bit          stt_q[$];
  bit          bt_q[$];
  logic [6:0]  op_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .aluop(aluop),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .state(state), .error(error)
  );

  function automatic logic [19:0] pk(int st, bit req, bit we, bit asrc, bit irw, bit pcw, bit rw,
                                     int op, int a, int b, int rs);
    return {4'(st), (st == 15), req, we, asrc, irw, pcw, rw, 3'(op), 2'(a), 2'(b), 2'(rs)};
  endfunction

  function automatic logic [19:0] obs();
    return {state, error, mem_req, mem_we, addr_src, ir_write, pc_write, reg_write,
            aluop, alu_src_a, alu_src_b, result_src};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [19:0] e, input bit rdy, input bit stt, input bit bt,
                      input logic [6:0] op);
    exp_q.push_back(e); rdy_q.push_back(rdy); stt_q.push_back(stt);
    bt_q.push_back(bt); op_q.push_back(op);
  endtask

  task automatic clear_q();
    exp_q.delete(); rdy_q.delete(); stt_q.delete(); bt_q.delete(); op_q.delete();
  endtask

  // Expected trace of one instruction: fw/mw are memory wait cycles before READY.
  task automatic build_instr(input logic [6:0] op, input int fw, input int mw, input bit taken);
    for (int i = 0; i < fw; i++) push(pk(1, 1, 0, 0, 0, 0, 0, 2, 3, 2, 0), 0, rb(), rb(), op);
    push(pk(1, 1, 0, 0, 1, 1, 0, 2, 3, 2, 0), 1, rb(), rb(), op);
    push(pk(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0), rb(), rb(), rb(), op);
    case (op)
      OP_R, OP_I, OP_LUI, OP_AUIPC: begin
        if (op == OP_R)        push(pk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb(), rb(), op);
        else if (op == OP_I)   push(pk(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), rb(), rb(), rb(), op);
        else if (op == OP_LUI) push(pk(12, 0, 0, 0, 0, 0, 0, 5, 2, 1, 0), rb(), rb(), rb(), op);
        else                   push(pk(12, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0), rb(), rb(), rb(), op);
        push(pk(8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), rb(), 1, rb(), op);
      end
      OP_LOAD: begin
        push(pk(5, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0), rb(), rb(), rb(), op);
        for (int i = 0; i < mw; i++) push(pk(6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, rb(), rb(), op);
        push(pk(6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, rb(), rb(), op);
        push(pk(9, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), rb(), 1, rb(), op);
      end
      OP_STORE: begin
        push(pk(5, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0), rb(), rb(), rb(), op);
        for (int i = 0; i < mw; i++) push(pk(7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, rb(), rb(), op);
        push(pk(7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1, 1, rb(), op);
      end
      OP_BR:   push(pk(10, 0, 0, 0, 0, taken, 0, 4, 0, 0, 0), rb(), 1, taken, op);
      OP_JAL:  push(pk(11, 0, 0, 0, 0, 1, 1, 7, 1, 1, 2), rb(), 1, rb(), op);
      default: push(pk(11, 0, 0, 0, 0, 1, 1, 7, 0, 1, 2), rb(), 1, rb(), op);
    endcase
  endtask

  task automatic step(input bit rdy, input bit stt, input bit bt, input logic [6:0] op,
                      output logic [19:0] o);
    @(negedge clk);
    mem_ready = rdy; start = stt; branch_taken = bt; opcode = op;
    #1 o = obs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] o;
    rst_n = 1'b0; start = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; opcode = OP_R;
    repeat (2) @(negedge clk);
    #1 o = obs();
    checks++;
    if (o !== 20'h0) begin errors++; $display("FAIL reset_hold got %h want %h", o, 20'h0); end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, OP_R, o);
    checks++;
    if (o !== 20'h0) begin errors++; $display("FAIL reset_idle got %h want %h", o, 20'h0); end
  endtask

  task automatic test_random_program();
    logic [19:0] o;
    logic [6:0]  ops[9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    int fw, mw;
    do_reset();
    clear_q();
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), 0, rb(), OP_R);
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), 1, rb(), OP_R);
    for (int n = 0; n < 40; n++) begin
      fw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      build_instr(ops[$urandom_range(0, 8)], fw, mw, rb());
    end
    stt_q[$] = 1'b0;
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), 0, rb(), OP_R);
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), 0, rb(), OP_R);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(rdy_q[i], stt_q[i], bt_q[i], op_q[i], o);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL random_prog cyc %0d op %b got %h want %h", i, op_q[i], o, exp_q[i]);
      end
    end
  endtask

  task automatic test_branch_illegal();
    logic [19:0] o;
    do_reset();
    clear_q();
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, OP_BR);
    build_instr(OP_BR, 0, 0, 0);
    build_instr(OP_BR, 0, 0, 1);
    push(pk(1, 1, 0, 0, 1, 1, 0, 2, 3, 2, 0), 1, 1, 0, 7'h7f);
    push(pk(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0), 1, 1, 1, 7'h7f);
    for (int i = 0; i < 6; i++) push(pk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb(), rb(), 7'h7f);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(rdy_q[i], stt_q[i], bt_q[i], op_q[i], o);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL branch_illegal cyc %0d got %h want %h", i, o, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [19:0] o;
    do_reset();
    clear_q();
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, OP_R);
    for (int i = 0; i < 15; i++) push(pk(1, 1, 0, 0, 0, 0, 0, 2, 3, 2, 0), 0, 1, 0, OP_R);
    for (int i = 0; i < 3; i++) push(pk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), 1, 0, OP_R);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(rdy_q[i], stt_q[i], bt_q[i], op_q[i], o);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL fetch_timeout cyc %0d got %h want %h", i, o, exp_q[i]);
      end
    end
    do_reset();
    clear_q();
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, OP_LOAD);
    push(pk(1, 1, 0, 0, 1, 1, 0, 2, 3, 2, 0), 1, 1, 0, OP_LOAD);
    push(pk(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0), 1, 1, 0, OP_LOAD);
    push(pk(5, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0), 1, 1, 0, OP_LOAD);
    for (int i = 0; i < 15; i++) push(pk(6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, OP_LOAD);
    for (int i = 0; i < 3; i++) push(pk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), 1, 0, OP_LOAD);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(rdy_q[i], stt_q[i], bt_q[i], op_q[i], o);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL memrd_timeout cyc %0d got %h want %h", i, o, exp_q[i]);
      end
    end
    do_reset();
    clear_q();
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, OP_R);
    build_instr(OP_R, 14, 0, 0);
    stt_q[$] = 1'b0;
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, OP_R);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(rdy_q[i], stt_q[i], bt_q[i], op_q[i], o);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL ready_on_last cyc %0d got %h want %h", i, o, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midwrite_halt();
    logic [19:0] o;
    do_reset();
    clear_q();
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, OP_STORE);
    push(pk(1, 1, 0, 0, 1, 1, 0, 2, 3, 2, 0), 1, 1, 0, OP_STORE);
    push(pk(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0), 1, 1, 0, OP_STORE);
    push(pk(5, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0), 1, 1, 0, OP_STORE);
    for (int i = 0; i < 3; i++) push(pk(7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, OP_STORE);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(rdy_q[i], stt_q[i], bt_q[i], op_q[i], o);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL pre_reset_write cyc %0d got %h want %h", i, o, exp_q[i]);
      end
    end
    #1 rst_n = 1'b0;
    #1 o = obs();
    checks++;
    if (o !== 20'h0) begin errors++; $display("FAIL async_reset got %h want %h", o, 20'h0); end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    step(1, 0, 0, OP_R, o);
    checks++;
    if (o !== 20'h0) begin errors++; $display("FAIL post_reset_idle got %h want %h", o, 20'h0); end
    clear_q();
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, OP_R);
    build_instr(OP_R, 0, 0, 0);
    stt_q[$] = 1'b0;
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, OP_R);
    push(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, OP_R);
    for (int i = 0; i < exp_q.size(); i++) begin
      step(rdy_q[i], stt_q[i], bt_q[i], op_q[i], o);
      checks++;
      if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL halt_at_wb cyc %0d got %h want %h", i, o, exp_q[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_random_program();
    test_branch_illegal();
    test_timeout();
    test_reset_midwrite_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
